// File: rtl/sc_game_flow_pkg.sv
// Shared state encoding and elaboration helpers for the Frogger game-flow controller.
package sc_game_flow_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'h0,
    S_CLEAR    = 4'h1,
    S_IDLE     = 4'h2,
    S_PLAY     = 4'h3,
    S_PAUSE    = 4'h4,
    S_LEVELUP  = 4'h5,
    S_DEATH    = 4'h6,
    S_GAMEOVER = 4'h7,
    S_WIN      = 4'h8
  } state_t;

  // Bits needed to hold values 0..value-1; returns at least 1 for value >= 2.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sc_pause_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module sc_pause_timer #(
  parameter int W = 4
) (
  input  logic         SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic         SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sc_game_flow_fsm.sv
// Top-level game-flow controller: clear/idle/play/pause/level-up/death/game-over/win,
// owning the level and lives counters.
//
// state      | meaning
// S_RESET    | one cycle after reset, datapath held in clear
// S_CLEAR    | clear held low CLEAR_CYCLES cycles, counters reloaded on entry
// S_IDLE     | waiting for start
// S_PLAY     | objects and frog moving
// S_PAUSE    | movement frozen, events ignored
// S_LEVELUP  | goal reached, hold PAUSE_CYCLES then next level or win
// S_DEATH    | life lost on entry, hold PAUSE_CYCLES then play or game over
// S_GAMEOVER | no lives left, start restarts
// S_WIN      | last level cleared, start restarts
module sc_game_flow_fsm
  import sc_game_flow_pkg::*;
#(
  parameter int NUM_LEVELS   = 4,
  parameter int NUM_LIVES    = 3,
  parameter int LEVEL_W      = 3,
  parameter int LIVES_W      = 2,
  parameter int CLEAR_CYCLES = 2,
  parameter int PAUSE_CYCLES = 50000000,
  parameter int ENABLE_PAUSE = 1
) (
  input  logic               SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic               SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic               start_InHigh,
  input  logic               goal_InHigh,
  input  logic               collision_InHigh,
  input  logic               timeout_InHigh,
  output logic               clear_OutLow,
  output logic               run_OutHigh,
  output logic [LEVEL_W-1:0] level_Out,
  output logic [LIVES_W-1:0] lives_Out,
  output logic               levelup_OutHigh,
  output logic               gameover_OutHigh,
  output logic               win_OutHigh,
  output logic [3:0]         state_Out
);

  localparam int HOLD_MAX = (PAUSE_CYCLES > CLEAR_CYCLES) ? PAUSE_CYCLES : CLEAR_CYCLES;
  localparam int TMR_W    = clog2_f(HOLD_MAX + 1);

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(NUM_LIVES);

  state_t             state;
  state_t             state_nxt;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic               start_d;
  logic               start_edge;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_done;

  assign start_edge = start_InHigh & ~start_d;

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:    state_nxt = S_CLEAR;
      S_CLEAR:    if (tmr_done) state_nxt = S_IDLE;
      S_IDLE:     if (start_edge) state_nxt = S_PLAY;
      S_PLAY: begin
        if (collision_InHigh || timeout_InHigh) state_nxt = S_DEATH;
        else if (goal_InHigh)                   state_nxt = S_LEVELUP;
        else if ((ENABLE_PAUSE != 0) && start_edge) state_nxt = S_PAUSE;
      end
      S_PAUSE:    if (start_edge) state_nxt = S_PLAY;
      S_LEVELUP:  if (tmr_done) state_nxt = (level == LAST_LEVEL) ? S_WIN : S_PLAY;
      S_DEATH:    if (tmr_done) state_nxt = (lives == '0) ? S_GAMEOVER : S_PLAY;
      S_GAMEOVER: if (start_edge) state_nxt = S_CLEAR;
      S_WIN:      if (start_edge) state_nxt = S_CLEAR;
      default:    state_nxt = S_CLEAR;
    endcase
  end

  // Timer is loaded with N-1 on the edge that enters a hold state, so the hold lasts N cycles.
  always_comb begin
    tmr_load = (state_nxt != state) &&
               ((state_nxt == S_CLEAR) || (state_nxt == S_LEVELUP) || (state_nxt == S_DEATH));
    tmr_val  = (state_nxt == S_CLEAR) ? TMR_W'(CLEAR_CYCLES - 1) : TMR_W'(PAUSE_CYCLES - 1);
  end

  sc_pause_timer #(.W(TMR_W)) u_pause_timer (
    .SC_STATEMACHINEGENERAL_CLOCK_50     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .SC_STATEMACHINEGENERAL_RESET_InHigh (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .load                                (tmr_load),
    .load_val                            (tmr_val),
    .done                                (tmr_done)
  );

  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      state            <= S_RESET;
      level            <= '0;
      lives            <= FULL_LIVES;
      start_d          <= 1'b0;
      clear_OutLow     <= 1'b0;
      run_OutHigh      <= 1'b0;
      levelup_OutHigh  <= 1'b0;
      gameover_OutHigh <= 1'b0;
      win_OutHigh      <= 1'b0;
    end else begin
      start_d <= start_InHigh;
      state   <= state_nxt;

      if ((state_nxt == S_CLEAR) && (state != S_CLEAR)) begin
        level <= '0;
        lives <= FULL_LIVES;
      end else if ((state_nxt == S_DEATH) && (state != S_DEATH) && (lives != '0)) begin
        lives <= lives - LIVES_W'(1);
      end else if ((state == S_LEVELUP) && (state_nxt == S_PLAY)) begin
        level <= level + LEVEL_W'(1);
      end

      // Outputs are decoded from the next state so they line up with the state register.
      clear_OutLow     <= !((state_nxt == S_RESET) || (state_nxt == S_CLEAR));
      run_OutHigh      <= (state_nxt == S_PLAY);
      levelup_OutHigh  <= (state_nxt == S_LEVELUP) && (state != S_LEVELUP);
      gameover_OutHigh <= (state_nxt == S_GAMEOVER);
      win_OutHigh      <= (state_nxt == S_WIN);
    end
  end

  assign level_Out = level;
  assign lives_Out = lives;
  assign state_Out = state;

endmodule

// File: tb/tb_sc_game_flow_fsm.sv
// Self-checking bench for sc_game_flow_fsm: directed scenarios plus randomized play
// against a cycle-level behavioural model of the game rules.
module tb_sc_game_flow_fsm;
  import sc_game_flow_pkg::*;

  localparam int NL = 3;
  localparam int NV = 3;
  localparam int PC = 4;
  localparam int CC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, goal = 1'b0, collision = 1'b0, timeout = 1'b0;
  logic       clear_n, run, levelup, gameover, win;
  logic [1:0] level, lives;
  logic [3:0] state;

  always #5 clk = ~clk;

  sc_game_flow_fsm #(
    .NUM_LEVELS(NL), .NUM_LIVES(NV), .LEVEL_W(2), .LIVES_W(2),
    .CLEAR_CYCLES(CC), .PAUSE_CYCLES(PC), .ENABLE_PAUSE(1)
  ) dut (
    .SC_STATEMACHINEGENERAL_CLOCK_50     (clk),
    .SC_STATEMACHINEGENERAL_RESET_InHigh (rst),
    .start_InHigh                        (start),
    .goal_InHigh                         (goal),
    .collision_InHigh                    (collision),
    .timeout_InHigh                      (timeout),
    .clear_OutLow                        (clear_n),
    .run_OutHigh                         (run),
    .level_Out                           (level),
    .lives_Out                           (lives),
    .levelup_OutHigh                     (levelup),
    .gameover_OutHigh                    (gameover),
    .win_OutHigh                         (win),
    .state_Out                           (state)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [12:0] obs;
  assign obs = {state, clear_n, run, level, lives, levelup, gameover, win};

  // Model: game mode, cycles spent in it (1 = first cycle), level, lives, last start value.
  typedef enum int {M_RESET, M_CLEAR, M_IDLE, M_PLAY, M_PAUSE, M_LVL, M_DEATH, M_OVER, M_WIN} mode_e;
  mode_e m_mode;
  int    m_age, m_level, m_lives;
  bit    m_prev_start;

  function automatic void model_reset();
    m_mode = M_RESET; m_age = 1; m_level = 0; m_lives = NV; m_prev_start = 1'b0;
  endfunction

  function automatic void model_advance();
    mode_e nxt;
    bit    edge_s;
    edge_s = start && !m_prev_start;
    m_prev_start = start;
    nxt = m_mode;
    case (m_mode)
      M_RESET: nxt = M_CLEAR;
      M_CLEAR: if (m_age == CC) nxt = M_IDLE;
      M_IDLE:  if (edge_s) nxt = M_PLAY;
      M_PLAY:  if (collision || timeout) nxt = M_DEATH;
               else if (goal) nxt = M_LVL;
               else if (edge_s) nxt = M_PAUSE;
      M_PAUSE: if (edge_s) nxt = M_PLAY;
      M_LVL:   if (m_age == PC) begin
                 if (m_level == NL - 1) nxt = M_WIN;
                 else begin nxt = M_PLAY; m_level++; end
               end
      M_DEATH: if (m_age == PC) nxt = (m_lives == 0) ? M_OVER : M_PLAY;
      default: if (edge_s) nxt = M_CLEAR;
    endcase
    if (nxt != m_mode) begin
      m_age = 1;
      if (nxt == M_CLEAR) begin m_level = 0; m_lives = NV; end
      if (nxt == M_DEATH && m_lives > 0) m_lives--;
    end else begin
      m_age++;
    end
    m_mode = nxt;
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [3:0] s;
    case (m_mode)
      M_RESET: s = S_RESET;
      M_CLEAR: s = S_CLEAR;
      M_IDLE:  s = S_IDLE;
      M_PLAY:  s = S_PLAY;
      M_PAUSE: s = S_PAUSE;
      M_LVL:   s = S_LEVELUP;
      M_DEATH: s = S_DEATH;
      M_OVER:  s = S_GAMEOVER;
      default: s = S_WIN;
    endcase
    return {s, !(m_mode == M_RESET || m_mode == M_CLEAR), m_mode == M_PLAY,
            2'(m_level), 2'(m_lives), (m_mode == M_LVL) && (m_age == 1),
            m_mode == M_OVER, m_mode == M_WIN};
  endfunction

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (obs !== exp_vec() || clear_n !== 1'b0 || state !== S_RESET) begin
      n_fails++; $display("FAIL reset_hold got %h want %h", obs, exp_vec());
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL reset_release cyc%0d got %h want %h", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (state !== S_IDLE || clear_n !== 1'b1 || level !== 2'd0 || lives !== 2'd3 || run !== 1'b0) begin
      n_fails++; $display("FAIL reset_idle got st=%0d clr=%b lvl=%0d liv=%0d run=%b want st=%0d clr=1 lvl=0 liv=3 run=0",
                          state, clear_n, level, lives, run, S_IDLE);
    end
  endtask

  task automatic test_levels();
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int l = 0; l < NL; l++) begin
      goal = 1'b1; tick(); goal = 1'b0;
      n_checks++;
      if (levelup !== 1'b1 || run !== 1'b0) begin
        n_fails++; $display("FAIL levelup_pulse lvl%0d got lu=%b run=%b want lu=1 run=0", l, levelup, run);
      end
      for (int i = 0; i < 6; i++) begin
        tick();
        n_checks++;
        if (obs !== exp_vec()) begin
          n_fails++; $display("FAIL levels lvl%0d cyc%0d got %h want %h", l, i, obs, exp_vec());
        end
      end
    end
    n_checks++;
    if (win !== 1'b1 || level !== 2'd2 || state !== S_WIN) begin
      n_fails++; $display("FAIL win got win=%b lvl=%0d st=%0d want win=1 lvl=2 st=%0d", win, level, state, S_WIN);
    end
  endtask

  task automatic test_gameover();
    start = 1'b1; tick(); start = 1'b0;
    repeat (CC) tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    n_checks++;
    if (state !== S_PLAY || level !== 2'd0 || lives !== 2'd3) begin
      n_fails++; $display("FAIL restart got st=%0d lvl=%0d liv=%0d want st=%0d lvl=0 liv=3", state, level, lives, S_PLAY);
    end
    for (int k = 0; k < 3; k++) begin
      collision = 1'b1; tick(); collision = 1'b0;
      n_checks++;
      if (lives !== 2'(2 - k) || state !== S_DEATH) begin
        n_fails++; $display("FAIL death_lives k%0d got liv=%0d st=%0d want liv=%0d st=%0d", k, lives, state, 2 - k, S_DEATH);
      end
      for (int i = 0; i < 10; i++) begin
        tick();
        n_checks++;
        if (obs !== exp_vec()) begin
          n_fails++; $display("FAIL gameover k%0d cyc%0d got %h want %h", k, i, obs, exp_vec());
        end
      end
    end
    n_checks++;
    if (gameover !== 1'b1 || state !== S_GAMEOVER) begin
      n_fails++; $display("FAIL gameover_flag got go=%b st=%0d want go=1 st=%0d", gameover, state, S_GAMEOVER);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (state !== S_CLEAR || lives !== 2'd3 || level !== 2'd0 || clear_n !== 1'b0) begin
      n_fails++; $display("FAIL gameover_clear got st=%0d liv=%0d lvl=%0d clr=%b want st=%0d liv=3 lvl=0 clr=0",
                          state, lives, level, clear_n, S_CLEAR);
    end
  endtask

  task automatic test_priority();
    repeat (CC) tick();
    start = 1'b1; tick(); start = 1'b0;
    goal = 1'b1; tick(); goal = 1'b0;
    repeat (PC) tick();
    goal = 1'b1; collision = 1'b1; tick(); goal = 1'b0; collision = 1'b0;
    n_checks++;
    if (state !== S_DEATH || lives !== 2'd2 || level !== 2'd1 || obs !== exp_vec()) begin
      n_fails++; $display("FAIL priority got st=%0d liv=%0d lvl=%0d want st=%0d liv=2 lvl=1", state, lives, level, S_DEATH);
    end
    repeat (PC) tick();
    n_checks++;
    if (obs !== exp_vec() || state !== S_PLAY) begin
      n_fails++; $display("FAIL priority_resume got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_pause();
    int entries;
    logic [3:0] prev;
    entries = 0;
    prev = state;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state === S_PAUSE && prev !== S_PAUSE) entries++;
      prev = state;
    end
    n_checks++;
    if (entries !== 1 || state !== S_PAUSE || run !== 1'b0) begin
      n_fails++; $display("FAIL pause_entries got n=%0d st=%0d run=%b want n=1 st=%0d run=0", entries, state, run, S_PAUSE);
    end
    collision = 1'b1; tick(); collision = 1'b0; tick();
    n_checks++;
    if (state !== S_PAUSE || lives !== 2'd2 || obs !== exp_vec()) begin
      n_fails++; $display("FAIL pause_ignore got st=%0d liv=%0d want st=%0d liv=2", state, lives, S_PAUSE);
    end
    start = 1'b0; tick(); start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (state !== S_PLAY || run !== 1'b1) begin
      n_fails++; $display("FAIL pause_resume got st=%0d run=%b want st=%0d run=1", state, run, S_PLAY);
    end
  endtask

  task automatic test_reset_mid_death();
    collision = 1'b1; tick(); collision = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (state !== S_RESET || clear_n !== 1'b0 || lives !== 2'd3 || obs !== exp_vec()) begin
      n_fails++; $display("FAIL reset_mid_death got st=%0d clr=%b liv=%0d want st=%0d clr=0 liv=3", state, clear_n, lives, S_RESET);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) start = ~start;
      goal      = ($urandom_range(0, 19) == 0);
      collision = ($urandom_range(0, 29) == 0);
      timeout   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        tick();
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fails++; $display("FAIL random cyc%0d got %h want %h", i, obs, exp_vec());
      end
    end
    start = 1'b0; goal = 1'b0; collision = 1'b0; timeout = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_levels();
    test_gameover();
    test_priority();
    test_pause();
    test_reset_mid_death();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sc_game_flow_fsm.md
Name: sc_game_flow_fsm

Overview:
- Parametrised top-level game-flow controller for the Frogger datapath; supersedes the two-state reset/start controller.
- Sequences clear, idle, play, level-up, death, game-over and win.
- Owns the level counter and lives counter, gates object movement, and drives the active-low clear to all sub-blocks.
- Sits between the input conditioners (buttons, collision/goal comparators, round timer) and the datapath/display.

Parameters:
NUM_LEVELS, 4, levels per game; must be >= 1; level index runs 0..NUM_LEVELS-1
NUM_LIVES, 3, lives at game start; must be >= 1
LEVEL_W, 3, width of level_Out; must satisfy 2^LEVEL_W >= NUM_LEVELS
LIVES_W, 2, width of lives_Out; must satisfy 2^LIVES_W > NUM_LIVES
CLEAR_CYCLES, 2, cycles clear_OutLow is held low in S_CLEAR; must be >= 1
PAUSE_CYCLES, 50000000, hold time in S_LEVELUP and S_DEATH (1 s at 50 MHz); must be >= 1
ENABLE_PAUSE, 1, when 1, a start edge during play toggles S_PAUSE

Ports:
SC_STATEMACHINEGENERAL_CLOCK_50  in  1  system clock, 50 MHz
SC_STATEMACHINEGENERAL_RESET_InHigh  in  1  reset, asynchronous, active-high
start_InHigh  in  1  debounced start button, level signal; rising edge detected internally
goal_InHigh  in  1  frog reached home row (from comparator)
collision_InHigh  in  1  frog hit a car or fell in water
timeout_InHigh  in  1  round timer expired
clear_OutLow  out  1  active-low synchronous clear to datapath
run_OutHigh  out  1  enables object/frog movement
level_Out  out  LEVEL_W  current level index
lives_Out  out  LIVES_W  remaining lives
levelup_OutHigh  out  1  one-cycle pulse on entry to S_LEVELUP
gameover_OutHigh  out  1  high while in S_GAMEOVER
win_OutHigh  out  1  high while in S_WIN
state_Out  out  4  state register, for debug/display

Behaviour:
- Reset (async, active-high): state=S_RESET, level=0, lives=NUM_LIVES, pause counter=0, start edge register=0.
- Reset values of outputs: clear_OutLow=0, run=0, levelup=0, gameover=0, win=0.
- Reset mid-operation aborts any state and any pause countdown immediately.
- States: S_RESET, S_CLEAR, S_IDLE, S_PLAY, S_PAUSE, S_LEVELUP, S_DEATH, S_GAMEOVER, S_WIN.
- Outputs are Moore outputs decoded from the state register. levelup_OutHigh is registered so it is high exactly the first cycle in S_LEVELUP.
- start_edge = start_InHigh AND NOT start_d (start_d is start_InHigh registered one cycle).
- Transitions:
  - S_RESET -> S_CLEAR unconditionally, next cycle.
  - S_CLEAR: clear_OutLow=0 for CLEAR_CYCLES cycles. On entry, level:=0 and lives:=NUM_LIVES. Then -> S_IDLE.
  - S_IDLE: -> S_PLAY on start_edge.
  - S_PLAY: run=1. Event priority: collision|timeout > goal > start_edge.
    - collision or timeout -> S_DEATH.
    - goal -> S_LEVELUP.
    - start_edge with ENABLE_PAUSE=1 -> S_PAUSE.
  - S_PAUSE: run=0. -> S_PLAY on start_edge. goal/collision/timeout are ignored.
  - S_LEVELUP: run=0. Hold PAUSE_CYCLES cycles, then:
    - if level==NUM_LEVELS-1 -> S_WIN;
    - else level:=level+1 and -> S_PLAY.
  - S_DEATH: run=0. lives is decremented on entry. Hold PAUSE_CYCLES cycles, then:
    - if lives==0 -> S_GAMEOVER;
    - else -> S_PLAY.
  - S_GAMEOVER / S_WIN: -> S_CLEAR on start_edge. Otherwise stay indefinitely.
- Boundaries:
  - lives never underflows below 0.
  - level never exceeds NUM_LEVELS-1; level stays at the last index in S_WIN.
  - NUM_LEVELS=1: first goal leads to S_WIN.
  - Illegal state encoding -> S_CLEAR.
- Latency: event sampled in cycle N gives the new state and outputs in cycle N+1.

Decomposition:
- Package sc_game_flow_pkg: state encoding localparams (4-bit), log2 helper function.
- Sub-module sc_pause_timer:
  - Loadable down-counter, width $clog2(PAUSE_CYCLES+1).
  - load input, done output.
  - Shared by S_LEVELUP and S_DEATH, and reused for the S_CLEAR hold.

Test Plan (NUM_LEVELS=3, NUM_LIVES=3, PAUSE_CYCLES=4, CLEAR_CYCLES=2):
1. Assert reset 3 cycles, release -> clear_OutLow=0 for cycle 1 (S_RESET) plus 2 cycles (S_CLEAR), then S_IDLE with clear=1, level=0, lives=3, run=0.
2. Start edge, then goal pulse -> levelup pulse 1 cycle, run=0 for 4 cycles, then S_PLAY with level=1; repeat to level=2; third goal -> S_WIN, win=1, level stays 2.
3. Three collision pulses separated by 10 cycles -> lives 2,1,0; after the third hold -> S_GAMEOVER, gameover=1; start edge -> S_CLEAR, lives=3, level=0.
4. goal and collision asserted in the same cycle in S_PLAY -> S_DEATH, lives decrements, level unchanged.
5. Start held high for 20 cycles in S_PLAY -> exactly one transition to S_PAUSE; collision during pause ignored; next start edge -> S_PLAY.
6. Reset asserted mid S_DEATH countdown -> same cycle state=S_RESET, clear=0, lives=3.
